// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, opcode/funct values and
// instruction field positions. Used by the issue stage, ALU and ALU control.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SRA = 4'd11,
    ALU_NOR = 4'd12,
    ALU_SLL = 4'd14,
    ALU_SRL = 4'd15
  } alu_ctrl_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // lui is realised as a 16-bit left shift of the zero-extended immediate
  localparam logic [4:0] LUI_SHAMT = 5'd16;

  // Instruction field accessors
  function automatic logic [5:0] f_op(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] instr);
    return instr[10:6];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] instr);
    return instr[15:0];
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decode of an instruction plus register read data into
// ALU control, operands, shift amount and writeback destination.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  output logic [3:0]    o_ctrl,
  output logic [DW-1:0] o_a,
  output logic [DW-1:0] o_b,
  output logic [4:0]    o_shamt,
  output logic          o_wreg,
  output logic [RW-1:0] o_wdest,
  output logic          o_illegal
);

  logic [15:0]   w_imm;
  logic [DW-1:0] w_imm_sx;
  logic [DW-1:0] w_imm_zx;

  assign w_imm    = f_imm(instr);
  assign w_imm_sx = {{(DW-16){w_imm[15]}}, w_imm};
  assign w_imm_zx = {{(DW-16){1'b0}}, w_imm};

  // Opcode/funct decode; anything unrecognised is flagged illegal with no writeback
  always_comb begin
    o_ctrl    = ALU_AND;
    o_a       = rs_data;
    o_b       = rt_data;
    o_shamt   = '0;
    o_wreg    = 1'b0;
    o_wdest   = RW'(f_rt(instr));
    o_illegal = 1'b0;
    unique case (f_op(instr))
      OP_RTYPE: begin
        o_wreg  = 1'b1;
        o_wdest = RW'(f_rd(instr));
        case (f_funct(instr))
          FN_ADD, FN_ADDU: o_ctrl = ALU_ADD;
          FN_SUB, FN_SUBU: o_ctrl = ALU_SUB;
          FN_AND:          o_ctrl = ALU_AND;
          FN_OR:           o_ctrl = ALU_OR;
          FN_NOR:          o_ctrl = ALU_NOR;
          FN_SLT:          o_ctrl = ALU_SLT;
          FN_SLL: begin
            o_ctrl  = ALU_SLL;
            o_shamt = f_shamt(instr);
          end
          FN_SRL: begin
            o_ctrl  = ALU_SRL;
            o_shamt = f_shamt(instr);
          end
          FN_SRA: begin
            o_ctrl  = ALU_SRA;
            o_shamt = f_shamt(instr);
          end
          default: begin
            o_wreg    = 1'b0;
            o_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        o_ctrl = ALU_ADD;
        o_b    = w_imm_sx;
        o_wreg = 1'b1;
      end
      OP_SLTI: begin
        o_ctrl = ALU_SLT;
        o_b    = w_imm_sx;
        o_wreg = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl = ALU_AND;
        o_b    = w_imm_zx;
        o_wreg = 1'b1;
      end
      OP_ORI: begin
        o_ctrl = ALU_OR;
        o_b    = w_imm_zx;
        o_wreg = 1'b1;
      end
      OP_LUI: begin
        o_ctrl  = ALU_SLL;
        o_b     = w_imm_zx;
        o_shamt = LUI_SHAMT;
        o_wreg  = 1'b1;
      end
      OP_SW: begin
        o_ctrl = ALU_ADD;
        o_b    = w_imm_sx;
      end
      OP_BEQ, OP_BNE: begin
        o_ctrl = ALU_SUB;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue register: decoded instruction is held in a main output
// register backed by one skid entry so in_ready is a pure flop output.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    ALUCtrl,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic [4:0]    shamt,
  output logic          wreg,
  output logic [RW-1:0] wdest,
  output logic          illegal
);

  logic [3:0]    w_ctrl;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [4:0]    w_shamt;
  logic          w_wreg;
  logic [RW-1:0] w_wdest;
  logic          w_illegal;

  alu_issue_decode #(.DW(DW), .RW(RW)) u_decode (
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .o_ctrl    (w_ctrl),
    .o_a       (w_a),
    .o_b       (w_b),
    .o_shamt   (w_shamt),
    .o_wreg    (w_wreg),
    .o_wdest   (w_wdest),
    .o_illegal (w_illegal)
  );

  logic          r_out_valid;
  logic [3:0]    r_ctrl;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [4:0]    r_shamt;
  logic          r_wreg;
  logic [RW-1:0] r_wdest;
  logic          r_illegal;

  logic          r_skid_valid;
  logic [3:0]    r_skid_ctrl;
  logic [DW-1:0] r_skid_a;
  logic [DW-1:0] r_skid_b;
  logic [4:0]    r_skid_shamt;
  logic          r_skid_wreg;
  logic [RW-1:0] r_skid_wdest;
  logic          r_skid_illegal;

  logic w_accept;
  logic w_main_free;

  assign in_ready    = ~r_skid_valid;
  assign w_accept    = in_valid & ~r_skid_valid;
  // Main register can take new data when empty or being consumed this cycle
  assign w_main_free = ~r_out_valid | out_ready;

  // Main/skid registers: flush wins, then skid drains into main before new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid    <= 1'b0;
      r_ctrl         <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_shamt        <= '0;
      r_wreg         <= 1'b0;
      r_wdest        <= '0;
      r_illegal      <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_ctrl    <= '0;
      r_skid_a       <= '0;
      r_skid_b       <= '0;
      r_skid_shamt   <= '0;
      r_skid_wreg    <= 1'b0;
      r_skid_wdest   <= '0;
      r_skid_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_wreg       <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_wreg  <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // in_ready is low here, so no new accept can collide with the move
        r_out_valid  <= 1'b1;
        r_ctrl       <= r_skid_ctrl;
        r_a          <= r_skid_a;
        r_b          <= r_skid_b;
        r_shamt      <= r_skid_shamt;
        r_wreg       <= r_skid_wreg;
        r_wdest      <= r_skid_wdest;
        r_illegal    <= r_skid_illegal;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_ctrl      <= w_ctrl;
        r_a         <= w_a;
        r_b         <= w_b;
        r_shamt     <= w_shamt;
        r_wreg      <= w_wreg;
        r_wdest     <= w_wdest;
        r_illegal   <= w_illegal;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid   <= 1'b1;
      r_skid_ctrl    <= w_ctrl;
      r_skid_a       <= w_a;
      r_skid_b       <= w_b;
      r_skid_shamt   <= w_shamt;
      r_skid_wreg    <= w_wreg;
      r_skid_wdest   <= w_wdest;
      r_skid_illegal <= w_illegal;
    end
  end

  assign out_valid = r_out_valid;
  assign ALUCtrl   = r_ctrl;
  assign A         = r_a;
  assign B         = r_b;
  assign shamt     = r_shamt;
  assign wreg      = r_wreg;
  assign wdest     = r_wdest;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        wreg;
  logic [4:0]  wdest;
  logic        illegal;

  alu_issue_stage #(.DW(32), .RW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUCtrl   (ALUCtrl),
    .A         (A),
    .B         (B),
    .shamt     (shamt),
    .wreg      (wreg),
    .wdest     (wdest),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        wr;
    logic [4:0]  wd;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] rs;
    logic [31:0] rt;
    exp_t        e;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  bit   flushed_last = 0;

  // Reference decode straight from the instruction-set table
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op = i[31:26];
    logic [5:0]  fn = i[5:0];
    logic [31:0] sx = 32'($signed(i[15:0]));
    logic [31:0] zx = 32'(i[15:0]);
    e = '{ctrl: 4'd0, a: rs, b: rt, sh: 5'd0, wr: 1'b0, wd: i[20:16], ill: 1'b1};
    if (op == 6'h00) begin
      e.wd = i[15:11]; e.wr = 1'b1; e.ill = 1'b0;
      if (fn == 6'h20 || fn == 6'h21) e.ctrl = 4'd2;
      else if (fn == 6'h22 || fn == 6'h23) e.ctrl = 4'd6;
      else if (fn == 6'h24) e.ctrl = 4'd0;
      else if (fn == 6'h25) e.ctrl = 4'd1;
      else if (fn == 6'h27) e.ctrl = 4'd12;
      else if (fn == 6'h2A) e.ctrl = 4'd7;
      else if (fn == 6'h00) begin e.ctrl = 4'd14; e.sh = i[10:6]; end
      else if (fn == 6'h02) begin e.ctrl = 4'd15; e.sh = i[10:6]; end
      else if (fn == 6'h03) begin e.ctrl = 4'd11; e.sh = i[10:6]; end
      else begin e.wr = 1'b0; e.ill = 1'b1; end
    end else if (op == 6'h08 || op == 6'h09 || op == 6'h23) begin
      e.ctrl = 4'd2; e.b = sx; e.wr = 1'b1; e.ill = 1'b0;
    end else if (op == 6'h0A) begin
      e.ctrl = 4'd7; e.b = sx; e.wr = 1'b1; e.ill = 1'b0;
    end else if (op == 6'h0C) begin
      e.ctrl = 4'd0; e.b = zx; e.wr = 1'b1; e.ill = 1'b0;
    end else if (op == 6'h0D) begin
      e.ctrl = 4'd1; e.b = zx; e.wr = 1'b1; e.ill = 1'b0;
    end else if (op == 6'h0F) begin
      e.ctrl = 4'd14; e.b = zx; e.sh = 5'd16; e.wr = 1'b1; e.ill = 1'b0;
    end else if (op == 6'h2B) begin
      e.ctrl = 4'd2; e.b = sx; e.ill = 1'b0;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.ctrl = 4'd6; e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i = $urandom;
    logic [5:0] ops[11] = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fns[11] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    int k = $urandom_range(0, 19);
    if (k < 9) begin
      i[31:26] = 6'h00; i[5:0] = fns[$urandom_range(0, 10)];
    end else if (k < 18) begin
      i[31:26] = ops[$urandom_range(1, 10)];
    end else if (k == 18) begin
      i[31:26] = 6'h00; i[5:0] = 6'h26;
    end else begin
      i[31:26] = 6'h02;
    end
    return i;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk_entry(input string name, input exp_t e);
    chk({name, ".ctrl"}, 64'(ALUCtrl), 64'(e.ctrl));
    chk({name, ".wreg"}, 64'(wreg), 64'(e.wr));
    chk({name, ".illegal"}, 64'(illegal), 64'(e.ill));
    if (!e.ill) begin
      chk({name, ".A"}, 64'(A), 64'(e.a));
      chk({name, ".B"}, 64'(B), 64'(e.b));
      chk({name, ".shamt"}, 64'(shamt), 64'(e.sh));
      chk({name, ".wdest"}, 64'(wdest), 64'(e.wd));
    end
  endtask

  // Compare DUT against the occupancy/order model
  task automatic check_model();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) chk_entry("head", q[0]);
    if (flushed_last) chk("flush_wreg", 64'(wreg), 64'd0);
  endtask

  // Drive one cycle at the negedge, update the model, check at the next negedge
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] rs,
                      input logic [31:0] rt, input logic fl, input logic ordy);
    bit mv = q.size() > 0;
    bit mr = q.size() < 2;
    in_valid = iv; instr = ins; rs_data = rs; rt_data = rt; flush = fl; out_ready = ordy;
    if (fl) q.delete();
    else begin
      if (mv && ordy) void'(q.pop_front());
      if (iv && mr) q.push_back(ref_dec(ins, rs, rt));
    end
    flushed_last = fl;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({name, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({name, ".fields"}, {ALUCtrl, A, B, shamt, wreg, wdest, illegal},
        64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'h2109FFFC, 32'd10, 32'd77, '{4'd2, 32'd10, 32'hFFFFFFFC, 5'd0, 1'b1, 5'd9, 1'b0}});
    vecs.push_back('{32'h3C081234, 32'h55, 32'h66, '{4'd14, 32'h55, 32'h00001234, 5'd16, 1'b1, 5'd8, 1'b0}});
    vecs.push_back('{32'h000950C3, 32'h1, 32'h80000010, '{4'd11, 32'h1, 32'h80000010, 5'd3, 1'b1, 5'd10, 1'b0}});
    vecs.push_back('{32'h00851024, 32'hF0F0, 32'h0FF0, '{4'd0, 32'hF0F0, 32'h0FF0, 5'd0, 1'b1, 5'd2, 1'b0}});
    vecs.push_back('{32'h00851026, 32'h3, 32'h4, '{4'd0, 32'h3, 32'h4, 5'd0, 1'b0, 5'd2, 1'b1}});
    vecs.push_back('{32'h11090003, 32'h7, 32'h9, '{4'd6, 32'h7, 32'h9, 5'd0, 1'b0, 5'd9, 1'b0}});
    vecs.push_back('{32'h2909FFFF, 32'h2, 32'h0, '{4'd7, 32'h2, 32'hFFFFFFFF, 5'd0, 1'b1, 5'd9, 1'b0}});
    vecs.push_back('{32'h31098001, 32'h2, 32'h0, '{4'd0, 32'h2, 32'h00008001, 5'd0, 1'b1, 5'd9, 1'b0}});
    vecs.push_back('{32'hAD09FFF8, 32'h100, 32'h0, '{4'd2, 32'h100, 32'hFFFFFFF8, 5'd0, 1'b0, 5'd9, 1'b0}});
    vecs.push_back('{32'h00094080, 32'h0, 32'h5, '{4'd14, 32'h0, 32'h5, 5'd2, 1'b1, 5'd8, 1'b0}});
    vecs.push_back('{32'h01095020, 32'hA, 32'hB, '{4'd2, 32'hA, 32'hB, 5'd0, 1'b1, 5'd10, 1'b0}});
    vecs.push_back('{32'h010950E2, 32'hA, 32'hB, '{4'd6, 32'hA, 32'hB, 5'd0, 1'b1, 5'd10, 1'b0}});

    rst_n = 1'b0; in_valid = 0; instr = 0; rs_data = 0; rt_data = 0; flush = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_model();

    // Directed decode table, consumed every cycle
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].ins, vecs[i].rs, vecs[i].rt, 1'b0, 1'b1);
      chk_entry($sformatf("vec%0d", i), vecs[i].e);
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
    end
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // Backpressure: three held cycles with input pending, then drain
    step(1'b1, 32'h2109FFFC, 32'd10, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h3C081234, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("bp.in_ready_low", 64'(in_ready), 64'd0);
    step(1'b1, 32'h000950C3, 32'd3, 32'd4, 1'b0, 1'b0);
    step(1'b1, 32'h000950C3, 32'd3, 32'd4, 1'b0, 1'b0);
    chk("bp.held_ctrl", 64'(ALUCtrl), 64'd2);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    chk("bp.second_ctrl", 64'(ALUCtrl), 64'd14);
    chk("bp.in_ready_high", 64'(in_ready), 64'd1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    chk("bp.drained", 64'(out_valid), 64'd0);

    // Flush with main and skid full plus a pending input
    step(1'b1, 32'h2109FFFC, 32'd10, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h01095020, 32'd1, 32'd2, 1'b0, 1'b0);
    step(1'b1, 32'h3C081234, 32'd1, 32'd2, 1'b1, 1'b0);
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h00851024, 32'h3, 32'h5, 1'b0, 1'b1);
    chk("flush.after_ctrl", 64'(ALUCtrl), 64'd0);
    chk("flush.after_valid", 64'(out_valid), 64'd1);

    // Random traffic against the scoreboard
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom,
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
    end

    // Reset mid-stream with both entries occupied
    step(1'b1, 32'h2109FFFC, 32'd10, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h01095020, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("midrst.pre_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    q.delete();
    flushed_last = 0;
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model();
    step(1'b1, 32'h11090003, 32'd7, 32'd9, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
